// File: rtl/sap_ctrl_pkg.sv
// sap_ctrl_pkg: opcodes, T-state indices and control-word layout for the SAP controller.
package sap_ctrl_pkg;
   localparam logic [3:0] OP_LDA = 4'h0;
   localparam logic [3:0] OP_ADD = 4'h1;
   localparam logic [3:0] OP_SUB = 4'h2;
   localparam logic [3:0] OP_JMP = 4'h3;
   localparam logic [3:0] OP_JC  = 4'h4;
   localparam logic [3:0] OP_JZ  = 4'h5;
   localparam logic [3:0] OP_OUT = 4'he;
   localparam logic [3:0] OP_HLT = 4'hf;
   localparam int T1 = 0;
   localparam int T2 = 1;
   localparam int T3 = 2;
   localparam int T4 = 3;
   localparam int T5 = 4;
   localparam int T6 = 5;
   localparam int CW_W  = 13;
   localparam int CW_CP = 12;
   localparam int CW_EP = 11;
   localparam int CW_LP = 10;
   localparam int CW_LM = 9;
   localparam int CW_CE = 8;
   localparam int CW_LI = 7;
   localparam int CW_EI = 6;
   localparam int CW_LA = 5;
   localparam int CW_EA = 4;
   localparam int CW_SU = 3;
   localparam int CW_EU = 2;
   localparam int CW_LB = 1;
   localparam int CW_LO = 0;
   typedef logic [CW_W-1:0] ctrl_word_t;
   function automatic ctrl_word_t cw_bit(input int pos);
      return ctrl_word_t'(1) << pos;
   endfunction
endpackage

// File: rtl/controller_sequencer_ring_counter.sv
// ring_counter: one-hot T-state ring with async clear to T1 and a hold input.
module ring_counter #(
   parameter int NUM_T = 6
) (
   input  logic             clk,
   input  logic             clr,
   input  logic             hold,
   output logic [NUM_T-1:0] t_state
);
   always_ff @(posedge clk or posedge clr)
      if (clr) t_state <= {{(NUM_T-1){1'b0}}, 1'b1};
      else if (!hold) t_state <= {t_state[NUM_T-2:0], t_state[NUM_T-1]};
endmodule

// File: rtl/controller_sequencer.sv
// controller_sequencer: SAP instruction sequencer, fetch in T1-T3 and opcode decode in T4-T6.
// Optional CSEQ_JUMP_EN macro adds JMP/JC/JZ decoding; otherwise those opcodes are NOPs.
module controller_sequencer
   import sap_ctrl_pkg::*;
#(
   parameter int NUM_T    = 6,
   parameter int OPCODE_W = 4
) (
   input  logic                clk,
   input  logic                clr,
   input  logic [OPCODE_W-1:0] opcode,
   input  logic                carry_flag,
   input  logic                zero_flag,
   output logic                cp,
   output logic                ep,
   output logic                lp,
   output logic                lm,
   output logic                ce,
   output logic                li,
   output logic                ei,
   output logic                la,
   output logic                ea,
   output logic                su,
   output logic                eu,
   output logic                lb,
   output logic                lo,
   output logic                hlt,
   output logic [NUM_T-1:0]    t_state
);
   ctrl_word_t cw, ctl;
   logic halted, hlt_now;
   assign hlt_now = t_state[T4] & (opcode == OP_HLT);
   ring_counter #(.NUM_T(NUM_T)) u_ring (
      .clk    (clk),
      .clr    (clr),
      .hold   (halted | hlt_now),
      .t_state(t_state)
   );
   always_ff @(posedge clk or posedge clr)
      if (clr) halted <= 1'b0;
      else if (hlt_now) halted <= 1'b1;
   always_comb begin
      cw = '0;
      if (t_state[T1]) cw = cw_bit(CW_EP) | cw_bit(CW_LM);
      else if (t_state[T2]) cw = cw_bit(CW_CP);
      else if (t_state[T3]) cw = cw_bit(CW_CE) | cw_bit(CW_LI);
      else if (t_state[T4])
         case (opcode)
            OP_LDA, OP_ADD, OP_SUB: cw = cw_bit(CW_EI) | cw_bit(CW_LM);
            OP_OUT: cw = cw_bit(CW_EA) | cw_bit(CW_LO);
`ifdef CSEQ_JUMP_EN
            OP_JMP: cw = cw_bit(CW_EI) | cw_bit(CW_LP);
            OP_JC:  cw = cw_bit(CW_EI) | (carry_flag ? cw_bit(CW_LP) : '0);
            OP_JZ:  cw = cw_bit(CW_EI) | (zero_flag ? cw_bit(CW_LP) : '0);
`endif
            default: cw = '0;
         endcase
      else if (t_state[T5])
         case (opcode)
            OP_LDA: cw = cw_bit(CW_CE) | cw_bit(CW_LA);
            OP_ADD, OP_SUB: cw = cw_bit(CW_CE) | cw_bit(CW_LB);
            default: cw = '0;
         endcase
      else if (t_state[T6])
         case (opcode)
            OP_ADD: cw = cw_bit(CW_EU) | cw_bit(CW_LA);
            OP_SUB: cw = cw_bit(CW_SU) | cw_bit(CW_EU) | cw_bit(CW_LA);
            default: cw = '0;
         endcase
   end
   // reset and halt both silence every control line; hlt itself is only masked by reset
   assign ctl = (clr || halted) ? '0 : cw;
   assign hlt = !clr & (halted | hlt_now);
   assign cp = ctl[CW_CP];
   assign ep = ctl[CW_EP];
   assign lm = ctl[CW_LM];
   assign ce = ctl[CW_CE];
   assign li = ctl[CW_LI];
   assign ei = ctl[CW_EI];
   assign la = ctl[CW_LA];
   assign ea = ctl[CW_EA];
   assign su = ctl[CW_SU];
   assign eu = ctl[CW_EU];
   assign lb = ctl[CW_LB];
   assign lo = ctl[CW_LO];
`ifdef CSEQ_JUMP_EN
   assign lp = ctl[CW_LP];
`else
   logic unused_jump;
   assign unused_jump = carry_flag ^ zero_flag ^ ctl[CW_LP];
   assign lp = 1'b0;
`endif
endmodule
